// File: rtl/comm_mem_pkg.sv
// Shared constants and FSM state type for the communication memory and its block reader.
package comm_mem_pkg;

  localparam int MEM_WORDS = 25600;
  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } rd_state_t;

endpackage

// File: rtl/comm_mem_rd_fifo.sv
// Small synchronous FIFO carrying read words plus packet sop/eop flags.
// The head is read straight from the storage flops, so nothing bypasses the registers.
module comm_mem_rd_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    push_sop,
  input  logic                    push_eop,
  input  logic                    pop,
  output logic [DATA_W-1:0]       head_data,
  output logic                    head_sop,
  output logic                    head_eop,
  output logic                    head_valid,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_en;

  assign head_valid = (count != '0);
  assign pop_en     = pop && head_valid;
  assign head_data  = mem[rd_ptr].data;
  assign head_sop   = mem[rd_ptr].sop;
  assign head_eop   = mem[rd_ptr].eop;

  // NOTE: all state here is sequential, so every assignment is non-blocking to
  // keep evaluation order irrelevant. The storage is cleared too: it is only a few
  // words, and the head word must read as zero while the FIFO is empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_sop, push_eop, push_data};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_en) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop_en);
    end
  end

endmodule

// File: rtl/comm_mem_block_reader.sv
// Avalon-MM read master: fetches a contiguous block from the communication RAM
// and streams it out as one Avalon-ST packet with backpressure.
module comm_mem_block_reader #(
  parameter int ADDR_W     = comm_mem_pkg::ADDR_W,
  parameter int DATA_W     = comm_mem_pkg::DATA_W,
  parameter int MEM_WORDS  = comm_mem_pkg::MEM_WORDS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic              busy,
  output logic              done,
  output logic              cmd_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic              avm_clken,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop
);

  import comm_mem_pkg::rd_state_t;
  import comm_mem_pkg::IDLE;
  import comm_mem_pkg::RUN;
  import comm_mem_pkg::DRAIN;

  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

  rd_state_t         state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] issued;
  logic [ADDR_W-1:0] emitted;
  logic [ADDR_W-1:0] issue_idx;
  logic              inflight;
  logic              done_q;
  logic              err_q;
  logic [CNT_W-1:0]  fifo_count;
  logic [ADDR_W:0]   cmd_end;
  logic              issue;
  logic              handshake;
  logic              last_hs;

  assign cmd_end   = {1'b0, cmd_addr} + {1'b0, cmd_len};
  // fifo_count ignores a same-cycle pop, so the credit is conservative and the
  // word landing one cycle after issue always has a free slot.
  assign issue     = (state == RUN) && (issued != len) &&
                     ((fifo_count + CNT_W'(inflight)) < DEPTH_C);
  assign handshake = src_valid && src_ready;
  assign last_hs   = handshake && (emitted == len - ADDR_W'(1));

  assign cmd_ready      = (state == IDLE);
  assign busy           = (state != IDLE);
  assign done           = done_q;
  assign cmd_error      = err_q;
  assign avm_chipselect = issue;
  assign avm_address    = base + issued;
  assign avm_write      = 1'b0;
  assign avm_byteenable = 4'hF;
  assign avm_clken      = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      base      <= '0;
      len       <= '0;
      issued    <= '0;
      emitted   <= '0;
      issue_idx <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      inflight <= issue;
      if (issue) begin
        issued    <= issued + ADDR_W'(1);
        issue_idx <= issued;
      end
      if (handshake) emitted <= emitted + ADDR_W'(1);
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_end > MEM_LIMIT) begin
              err_q <= 1'b1;
            end else if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              base    <= cmd_addr;
              len     <= cmd_len;
              issued  <= '0;
              emitted <= '0;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (issue && (issued == len - ADDR_W'(1))) state <= DRAIN;
        end
        DRAIN: begin
          if (last_hs) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  comm_mem_rd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset_n),
    .push       (inflight),
    .push_data  (avm_readdata),
    .push_sop   (issue_idx == '0),
    .push_eop   (issue_idx == len - ADDR_W'(1)),
    .pop        (src_ready),
    .head_data  (src_data),
    .head_sop   (src_sop),
    .head_eop   (src_eop),
    .head_valid (src_valid),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_comm_mem_block_reader.sv
// Directed self-checking bench for comm_mem_block_reader with a latency-1 memory model.
module tb_comm_mem_block_reader;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 25600;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [ADDR_W-1:0] cmd_len = '0;
  logic              busy, done, cmd_error;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect, avm_write, avm_clken;
  logic [3:0]        avm_byteenable;
  logic [DATA_W-1:0] avm_readdata = '0;
  logic [DATA_W-1:0] src_data;
  logic              src_valid, src_sop, src_eop;
  logic              src_ready = 1'b1;

  always #5 clk = ~clk;

  comm_mem_block_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done), .cmd_error(cmd_error),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_clken(avm_clken), .avm_readdata(avm_readdata),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_sop(src_sop), .src_eop(src_eop)
  );

  // Memory model: latency 1, no waitrequest.
  logic [DATA_W-1:0] mem [MEM_WORDS];
  always @(posedge clk)
    if (avm_chipselect && (int'(avm_address) < MEM_WORDS)) avm_readdata <= mem[avm_address];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event log filled by the monitor on the falling edge.
  int                acc_q[$], cs_cyc_q[$], done_q[$], err_q[$], hs_cyc_q[$];
  bit                rdy_done_q[$];
  logic [ADDR_W-1:0] cs_addr_q[$];
  logic [DATA_W-1:0] hs_data_q[$];
  logic [1:0]        hs_flag_q[$];
  int                busy_cnt, valid_cnt, stab_err, n_cs, n_hs, max_out;
  bit                prev_stall;
  logic [DATA_W+1:0] prev_word;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
      if (avm_chipselect) begin
        cs_cyc_q.push_back(cyc);
        cs_addr_q.push_back(avm_address);
        n_cs++;
      end
      if (n_cs - n_hs > max_out) max_out = n_cs - n_hs;
      if (prev_stall && !(src_valid && {src_sop, src_eop, src_data} == prev_word)) stab_err++;
      prev_stall = src_valid && !src_ready;
      prev_word  = {src_sop, src_eop, src_data};
      if (src_valid) valid_cnt++;
      if (src_valid && src_ready) begin
        hs_cyc_q.push_back(cyc);
        hs_data_q.push_back(src_data);
        hs_flag_q.push_back({src_sop, src_eop});
        n_hs++;
      end
      if (done) begin
        done_q.push_back(cyc);
        rdy_done_q.push_back(cmd_ready);
      end
      if (cmd_error) err_q.push_back(cyc);
      if (busy) busy_cnt++;
    end
  end

  task automatic clear_log();
    acc_q.delete(); cs_cyc_q.delete(); done_q.delete(); err_q.delete(); hs_cyc_q.delete();
    rdy_done_q.delete(); cs_addr_q.delete(); hs_data_q.delete(); hs_flag_q.delete();
    busy_cnt = 0; valid_cnt = 0; stab_err = 0; n_cs = 0; n_hs = 0; max_out = 0;
  endtask

  task automatic issue_cmd(input int addr, input int len, output bit ok);
    int n0 = acc_q.size();
    int k = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = ADDR_W'(addr);
    cmd_len   = ADDR_W'(len);
    do begin
      @(posedge clk);
      k++;
    end while (acc_q.size() == n0 && k < 50);
    #1 cmd_valid = 1'b0;
    ok = (acc_q.size() > n0);
  endtask

  task automatic wait_events(input int n, input int budget);
    int k = 0;
    while ((done_q.size() + err_q.size()) < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
  endtask

  // Compares the logged words against mem[base..base+n-1] and the sop/eop markers.
  task automatic check_packet(input string tag, input int base, input int n);
    logic [63:0] sops = '0, eops = '0;
    check({tag, "_words"}, hs_data_q.size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_w%0d", tag, i),
            (i < hs_data_q.size()) ? hs_data_q[i] : 'x, mem[base + i]);
    for (int i = 0; i < hs_flag_q.size() && i < 64; i++) begin
      sops[i] = hs_flag_q[i][1];
      eops[i] = hs_flag_q[i][0];
    end
    check({tag, "_sop"}, sops, 64'd1);
    check({tag, "_eop"}, eops, 64'd1 << (n - 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"},
          {cmd_ready, busy, done, cmd_error, avm_chipselect, src_valid, src_sop, src_eop},
          8'b1000_0000);
    check({tag, "_addr"}, avm_address, 0);
    check({tag, "_data"}, src_data, 0);
  endtask

  initial begin
    bit ok;
    int c;
    logic [7:0] s5, e5;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[100] = 32'hA0; mem[101] = 32'hA1; mem[102] = 32'hA2; mem[103] = 32'hA3;

    // Reset state, including the tied-off Avalon controls.
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst");
    check("rst_const", {avm_write, avm_byteenable, avm_clken}, 6'b0_1111_1);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // A: four words at 100 with the sink always ready.
    clear_log();
    issue_cmd(100, 4, ok);
    check("A_accept", ok, 1);
    wait_events(1, 60);
    c = acc_q.size() > 0 ? acc_q[0] : 0;
    check_packet("A", 100, 4);
    check("A_cs_first", cs_cyc_q.size() > 0 ? cs_cyc_q[0] - c : -1, 1);
    check("A_cs_cnt", n_cs, 4);
    check("A_hs_first", hs_cyc_q.size() > 0 ? hs_cyc_q[0] - c : -1, 3);
    check("A_hs_last", hs_cyc_q.size() > 3 ? hs_cyc_q[3] - c : -1, 6);
    check("A_done_cnt", done_q.size(), 1);
    check("A_done_cyc", done_q.size() > 0 ? done_q[0] - c : -1, 7);
    check("A_rdy_at_done", rdy_done_q.size() > 0 ? rdy_done_q[0] : 0, 1);
    check("A_busy_cycles", busy_cnt, 6);

    // B: eight words at 100 with ready toggling 1,0,0,1.
    clear_log();
    issue_cmd(100, 8, ok);
    check("B_accept", ok, 1);
    for (int k = 0; k < 200 && done_q.size() == 0; k++) begin
      @(posedge clk); #1;
      src_ready = (k % 4 == 0) || (k % 4 == 3);
    end
    src_ready = 1'b1;
    repeat (4) @(posedge clk);
    check_packet("B", 100, 8);
    check("B_stable", stab_err, 0);
    check("B_max_buffered", max_out, 4);
    check("B_cs_cnt", n_cs, 8);

    // C: block ending exactly at the last word, then one word too far.
    clear_log();
    issue_cmd(25590, 10, ok);
    wait_events(1, 80);
    c = acc_q.size() > 0 ? acc_q[0] : 0;
    check_packet("C", 25590, 10);
    check("C_cs_first", cs_addr_q.size() > 0 ? cs_addr_q[0] : 'x, 25590);
    check("C_cs_last", cs_addr_q.size() == 10 ? cs_addr_q[9] : 'x, 25599);
    check("C_err_none", err_q.size(), 0);
    check("C_done_cyc", done_q.size() > 0 ? done_q[0] - c : -1, 13);
    clear_log();
    issue_cmd(25590, 11, ok);
    wait_events(1, 20);
    c = acc_q.size() > 0 ? acc_q[0] : 0;
    check("C11_err_cnt", err_q.size(), 1);
    check("C11_err_cyc", err_q.size() > 0 ? err_q[0] - c : -1, 1);
    check("C11_no_cs", n_cs, 0);
    check("C11_no_busy", busy_cnt, 0);
    check("C11_no_done", done_q.size(), 0);

    // D: zero-length command.
    clear_log();
    issue_cmd(5, 0, ok);
    wait_events(1, 20);
    c = acc_q.size() > 0 ? acc_q[0] : 0;
    check("D_done_cnt", done_q.size(), 1);
    check("D_done_cyc", done_q.size() > 0 ? done_q[0] - c : -1, 1);
    check("D_no_valid", valid_cnt, 0);
    check("D_no_cs", n_cs, 0);
    check("D_no_busy", busy_cnt, 0);
    check("D_no_err", err_q.size(), 0);

    // E: cmd_valid held through RUN; the second command waits for the first done.
    clear_log();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = 15'd200; cmd_len = 15'd3;
    for (int k = 0; k < 50 && acc_q.size() < 1; k++) @(posedge clk);
    #1 cmd_addr = 15'd300; cmd_len = 15'd2;
    for (int k = 0; k < 50 && acc_q.size() < 2; k++) @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_events(2, 60);
    check("E_acc_cnt", acc_q.size(), 2);
    check("E_done_cnt", done_q.size(), 2);
    check("E_done1_cyc", (done_q.size() > 0 && acc_q.size() > 0) ? done_q[0] - acc_q[0] : -1, 6);
    check("E_acc2_cyc", (done_q.size() > 0 && acc_q.size() > 1) ? acc_q[1] - done_q[0] : -1, 0);
    check("E_done2_cyc", (done_q.size() > 1 && acc_q.size() > 1) ? done_q[1] - acc_q[1] : -1, 5);
    check("E_words", hs_data_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("E_w%0d", i), (i < hs_data_q.size()) ? hs_data_q[i] : 'x,
            (i < 3) ? mem[200 + i] : mem[300 + i - 3]);
    s5 = '0; e5 = '0;
    for (int i = 0; i < hs_flag_q.size() && i < 8; i++) begin
      s5[i] = hs_flag_q[i][1];
      e5[i] = hs_flag_q[i][0];
    end
    check("E_sop", s5, 8'b0000_1001);
    check("E_eop", e5, 8'b0001_0100);

    // F: reset after two of eight words, then a fresh packet.
    clear_log();
    issue_cmd(400, 8, ok);
    for (int k = 0; k < 50 && n_hs < 2; k++) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_reset_outputs("F_rst");
    check("F_partial_words", n_hs, 2);
    check("F_partial_no_eop", hs_flag_q.size() == 2 ? {hs_flag_q[0][0], hs_flag_q[1][0]} : 2'bxx, 2'b00);
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("F_hold");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    clear_log();
    issue_cmd(100, 4, ok);
    wait_events(1, 60);
    c = acc_q.size() > 0 ? acc_q[0] : 0;
    check_packet("F_new", 100, 4);
    check("F_new_done_cyc", done_q.size() > 0 ? done_q[0] - c : -1, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
